// File: rtl/dec24_strobe.sv
// Qualified 2-to-4 decoder: a valid code must hold for STABLE_CYCLES samples
// before it produces one coin_pulse strobe and updates the held coin_level.
module dec24_strobe #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] code_in,
    input  logic       code_vld,
    output logic [3:0] coin_pulse,
    output logic [3:0] coin_level,
    output logic       busy,
    output logic [7:0] evt_cnt,
    output logic [7:0] glitch_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETTLE   = 2'd1;
    localparam logic [1:0] FIRE     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    localparam logic [8:0] TARGET = 9'(STABLE_CYCLES);

    logic [1:0] state;
    logic [1:0] cand;
    logic [7:0] cnt;

    logic [1:0] next_state;
    logic [1:0] next_cand;
    logic [7:0] next_cnt;
    logic       glitch_hit;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    always_comb begin
        next_state = state;
        next_cand  = cand;
        next_cnt   = cnt;
        glitch_hit = 1'b0;
        case (state)
            IDLE: begin
                if (code_vld) begin
                    next_cand  = code_in;
                    next_cnt   = 8'd1;
                    next_state = (TARGET == 9'd1) ? FIRE : SETTLE;
                end
            end
            SETTLE: begin
                if (!code_vld) begin
                    next_state = IDLE;
                    next_cnt   = 8'd0;
                end else if (code_in != cand) begin
                    next_cand  = code_in;
                    next_cnt   = 8'd1;
                    glitch_hit = 1'b1;
                end else if (({1'b0, cnt} + 9'd1) == TARGET) begin
                    next_state = FIRE;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            FIRE: begin
                next_state = WAIT_REL;
            end
            default: begin
                // WAIT_REL ignores code changes so a held press never re-fires
                if (!code_vld) begin
                    next_state = IDLE;
                    next_cnt   = 8'd0;
                end
            end
        endcase
    end

    // Strobe, level and event count all register on the edge that enters FIRE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cand       <= 2'b00;
            cnt        <= 8'd0;
            coin_pulse <= 4'b0000;
            coin_level <= 4'b0000;
            busy       <= 1'b0;
            evt_cnt    <= 8'd0;
            glitch_cnt <= 8'd0;
        end else begin
            state      <= next_state;
            cand       <= next_cand;
            cnt        <= next_cnt;
            busy       <= (next_state != IDLE);
            coin_pulse <= 4'b0000;
            if (next_state == FIRE) begin
                coin_pulse <= onehot(next_cand);
                coin_level <= onehot(next_cand);
                evt_cnt    <= evt_cnt + 8'd1;
            end
            if (glitch_hit && glitch_cnt != 8'hFF) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dec24_strobe.sv
// Bench for dec24_strobe: STABLE_CYCLES=4 and =1 instances share one stimulus
// stream; a run-length model predicts pulses into queues checked by a monitor.
module tb_dec24_strobe;

    typedef struct {
        int         edge_no;
        logic [3:0] pulse;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] code_in;
    logic       code_vld;

    logic [3:0] pulse4, level4, pulse1, level1;
    logic       busy4, busy1;
    logic [7:0] evt4, glitch4, evt1, glitch1;

    int   checks = 0;
    int   failures = 0;
    int   edge_count = 0;
    exp_t q4[$];
    exp_t q1[$];

    int         stable[2] = '{4, 1};
    bit         armed[2];
    bit         skip[2];
    int         run_len[2];
    logic [1:0] run_code[2];
    int         m_evt[2];
    int         m_glitch[2];
    logic [3:0] m_level[2];

    dec24_strobe #(.STABLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_vld(code_vld),
        .coin_pulse(pulse4), .coin_level(level4), .busy(busy4),
        .evt_cnt(evt4), .glitch_cnt(glitch4)
    );

    dec24_strobe #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_vld(code_vld),
        .coin_pulse(pulse1), .coin_level(level1), .busy(busy1),
        .evt_cnt(evt1), .glitch_cnt(glitch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            armed[k]    = 1'b1;
            skip[k]     = 1'b0;
            run_len[k]  = 0;
            run_code[k] = 2'b00;
            m_evt[k]    = 0;
            m_glitch[k] = 0;
            m_level[k]  = 4'b0000;
        end
    endtask

    // A press fires once a run of identical valid samples reaches the target
    // length; the next sample is swallowed and a release is needed to re-arm.
    task automatic model_step(input int k, input bit vld, input logic [1:0] code);
        exp_t e;
        if (skip[k]) begin
            skip[k] = 1'b0;
            return;
        end
        if (!vld) begin
            armed[k]   = 1'b1;
            run_len[k] = 0;
            return;
        end
        if (!armed[k]) return;
        if (run_len[k] > 0 && code != run_code[k]) begin
            if (m_glitch[k] < 255) m_glitch[k]++;
            run_len[k] = 1;
        end else begin
            run_len[k]++;
        end
        run_code[k] = code;
        if (run_len[k] == stable[k]) begin
            e.edge_no  = edge_count + 1;
            e.pulse    = 4'b0001 << code;
            if (k == 0) q4.push_back(e);
            else        q1.push_back(e);
            m_evt[k]   = (m_evt[k] + 1) % 256;
            m_level[k] = e.pulse;
            armed[k]   = 1'b0;
            skip[k]    = 1'b1;
            run_len[k] = 0;
        end
    endtask

    task automatic applyStimulus(input bit vld, input logic [1:0] code);
        code_vld = vld;
        code_in  = code;
        model_step(0, vld, code);
        model_step(1, vld, code);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, " S4 evt_cnt"},    int'(evt4),    m_evt[0]);
        compare({tag, " S4 glitch_cnt"}, int'(glitch4), m_glitch[0]);
        compare({tag, " S4 coin_level"}, int'(level4),  int'(m_level[0]));
        compare({tag, " S4 busy"},       int'(busy4),   int'(!armed[0] || run_len[0] > 0));
        compare({tag, " S1 evt_cnt"},    int'(evt1),    m_evt[1]);
        compare({tag, " S1 glitch_cnt"}, int'(glitch1), m_glitch[1]);
        compare({tag, " S1 coin_level"}, int'(level1),  int'(m_level[1]));
        compare({tag, " S1 busy"},       int'(busy1),   int'(!armed[1] || run_len[1] > 0));
    endtask

    task automatic check_pulse(input string tag, input logic [3:0] p, input exp_t e);
        compare({tag, " pulse value"}, int'(p), int'(e.pulse));
        compare({tag, " pulse edge"}, edge_count, e.edge_no);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pulse4 != 4'b0000) begin
            if (q4.size() == 0) compare("S4 unexpected pulse", int'(pulse4), 0);
            else begin
                e = q4.pop_front();
                check_pulse("S4", pulse4, e);
            end
        end
        if (pulse1 != 4'b0000) begin
            if (q1.size() == 0) compare("S1 unexpected pulse", int'(pulse1), 0);
            else begin
                e = q1.pop_front();
                check_pulse("S1", pulse1, e);
            end
        end
    end

    // Asynchronous reset between clock edges; outputs must clear before any edge
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare({tag, " S4 pulse"},  int'(pulse4),  0);
        compare({tag, " S4 level"},  int'(level4),  0);
        compare({tag, " S4 busy"},   int'(busy4),   0);
        compare({tag, " S4 evt"},    int'(evt4),    0);
        compare({tag, " S4 glitch"}, int'(glitch4), 0);
        compare({tag, " S1 level"},  int'(level1),  0);
        compare({tag, " S1 busy"},   int'(busy1),   0);
        compare({tag, " S1 evt"},    int'(evt1),    0);
        code_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] c;
        rst_n    = 1'b0;
        code_vld = 1'b0;
        code_in  = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b10);
        checkOutput("hold10");
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("release10");

        repeat (2) applyStimulus(1'b1, 2'b01);
        repeat (4) applyStimulus(1'b1, 2'b11);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("glitch");

        repeat (3) applyStimulus(1'b1, 2'b00);
        repeat (2) applyStimulus(1'b0, 2'b00);
        checkOutput("short");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i));
            repeat (2) applyStimulus(1'b0, 2'b00);
        end
        checkOutput("fourcodes");

        repeat (2) applyStimulus(1'b1, 2'b01);
        async_reset("rst_settle");
        repeat (3) applyStimulus(1'b0, 2'b00);
        checkOutput("after_rst_settle");

        repeat (6) applyStimulus(1'b1, 2'b11);
        checkOutput("wait_rel");
        async_reset("rst_waitrel");
        repeat (3) applyStimulus(1'b0, 2'b00);
        checkOutput("after_rst_waitrel");

        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'(i));
        checkOutput("toggle");
        repeat (2) applyStimulus(1'b0, 2'b00);

        for (int i = 0; i < 256; i++) begin
            c = 2'($urandom_range(0, 3));
            repeat (4) applyStimulus(1'b1, c);
            repeat (2) applyStimulus(1'b0, 2'b00);
        end
        checkOutput("wrap");

        c = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) c = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 9) < 7, c);
            if (i % 50 == 49) checkOutput("random");
        end
        repeat (3) applyStimulus(1'b0, 2'b00);
        checkOutput("final");

        compare("S4 pending pulses", q4.size(), 0);
        compare("S1 pending pulses", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
